// File: rtl/dmg_timer_periph.sv
// DMG timer/divider (DIV/TIMA/TMA/TAC) bus responder with delayed TMA reload and overflow IRQ.
// Optional build macro TIMER_DIV_GLITCH_EN: DIV/TAC writes that drop the tick signal produce a spurious TIMA tick.
module dmg_timer_periph #(
    parameter logic [15:0] BASE_ADDR    = 16'hFF04,
    parameter int          RELOAD_DELAY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_en,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [7:0]  bus_rdata,
    output logic        bus_rvalid,
    output logic        irq_timer
);

    localparam int CNT_W = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY) : 1;

    typedef enum logic [1:0] {
        COUNT   = 2'd0,
        PENDING = 2'd1,
        RELOAD  = 2'd2
    } timerState_e;

    timerState_e      state, stateNext;
    logic [15:0]      sysCnt, sysCntNext;
    logic [7:0]       tima, timaNext;
    logic [7:0]       tma, tmaNext;
    logic [2:0]       tac, tacNext;
    logic [CNT_W-1:0] delayCnt, delayNext;
    logic             sigQ, sigQNext, sig, fallEdge;
    logic             irqNext;

    logic [15:0] offset;
    logic [1:0]  regSel;
    logic        inWindow;
    logic        wrDiv, wrTima, wrTma, wrTac;
    logic [7:0]  readVal;

    function automatic logic tickSig(input logic [15:0] cnt, input logic [2:0] ctl);
        logic b;
        case (ctl[1:0])
            2'b00:   b = cnt[9];
            2'b01:   b = cnt[3];
            2'b10:   b = cnt[5];
            default: b = cnt[7];
        endcase
        return b & ctl[2];
    endfunction

    // Wrapping subtraction folds both window bounds into one compare.
    assign offset   = bus_addr - BASE_ADDR;
    assign inWindow = (offset[15:2] == 14'd0);
    assign regSel   = offset[1:0];

    assign wrDiv  = bus_we && inWindow && (regSel == 2'd0);
    assign wrTima = bus_we && inWindow && (regSel == 2'd1);
    assign wrTma  = bus_we && inWindow && (regSel == 2'd2);
    assign wrTac  = bus_we && inWindow && (regSel == 2'd3);

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sysCntNext = sysCnt;
        if (wrDiv)
            sysCntNext = 16'd0;
        else if (tick_en)
            sysCntNext = sysCnt + 16'd1;
        tmaNext = wrTma ? bus_wdata : tma;
        tacNext = wrTac ? bus_wdata[2:0] : tac;
    end

    assign sig      = tickSig(sysCnt, tac);
    assign fallEdge = sigQ & ~sig;

`ifdef TIMER_DIV_GLITCH_EN
    assign sigQNext = sig;
`else
    logic sigPost;
    assign sigPost  = tickSig(sysCntNext, tacNext);
    assign sigQNext = (wrDiv || wrTac) ? sigPost : sig;
`endif

    always_comb begin
        stateNext = state;
        timaNext  = tima;
        delayNext = delayCnt;
        irqNext   = 1'b0;
        case (state)
            COUNT: begin
                if (wrTima) begin
                    timaNext = bus_wdata;
                end else if (fallEdge) begin
                    if (tima == 8'hFF) begin
                        timaNext  = 8'h00;
                        stateNext = PENDING;
                        delayNext = CNT_W'(RELOAD_DELAY - 1);
                    end else begin
                        timaNext = tima + 8'd1;
                    end
                end
            end
            PENDING: begin
                if (wrTima) begin
                    timaNext  = bus_wdata;
                    stateNext = COUNT;
                end else if (tick_en) begin
                    if (delayCnt == '0)
                        stateNext = RELOAD;
                    else
                        delayNext = delayCnt - CNT_W'(1);
                end
            end
            RELOAD: begin
                timaNext  = tmaNext;
                irqNext   = 1'b1;
                stateNext = COUNT;
            end
            default: stateNext = COUNT;
        endcase
    end

    always_comb begin
        readVal = 8'h00;
        case (regSel)
            2'd0:    readVal = sysCnt[15:8];
            2'd1:    readVal = tima;
            2'd2:    readVal = tma;
            default: readVal = {5'b11111, tac};
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= COUNT;
            sysCnt     <= 16'd0;
            tima       <= 8'h00;
            tma        <= 8'h00;
            tac        <= 3'd0;
            delayCnt   <= '0;
            sigQ       <= 1'b0;
            irq_timer  <= 1'b0;
            bus_rdata  <= 8'h00;
            bus_rvalid <= 1'b0;
        end else begin
            state      <= stateNext;
            sysCnt     <= sysCntNext;
            tima       <= timaNext;
            tma        <= tmaNext;
            tac        <= tacNext;
            delayCnt   <= delayNext;
            sigQ       <= sigQNext;
            irq_timer  <= irqNext;
            bus_rvalid <= bus_re && inWindow;
            bus_rdata  <= (bus_re && inWindow) ? readVal : 8'h00;
        end
    end

endmodule

// File: tb/tb_dmg_timer_periph.sv
// Directed bench for dmg_timer_periph: register access table plus reload/cancel/glitch sequences.
module tb_dmg_timer_periph;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_en;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [7:0]  bus_rdata;
    logic        bus_rvalid;
    logic        irq_timer;

    int nChecks = 0;
    int nPass   = 0;
    int irqCount = 0;
    int irqBase;

    typedef struct {
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        expValid;
        logic [7:0]  expData;
    } vec_t;

    vec_t vecs[17];

    dmg_timer_periph #(.BASE_ADDR(16'hFF04), .RELOAD_DELAY(4)) dut (
        .clk(clk),
        .reset(reset),
        .tick_en(tick_en),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_we(bus_we),
        .bus_re(bus_re),
        .bus_rdata(bus_rdata),
        .bus_rvalid(bus_rvalid),
        .irq_timer(irq_timer)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (irq_timer === 1'b1) irqCount++;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            nPass++;
    endtask

    task automatic doReset();
        reset = 1'b1; tick_en = 1'b0; bus_we = 1'b0; bus_re = 1'b0;
        bus_addr = 16'h0000; bus_wdata = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick(input int n);
        tick_en = 1'b1;
        repeat (n) @(negedge clk);
        tick_en = 1'b0;
    endtask

    task automatic busWrite(input logic [15:0] addr, input logic [7:0] data);
        bus_addr = addr; bus_wdata = data; bus_we = 1'b1;
        @(negedge clk);
        bus_we = 1'b0;
    endtask

    task automatic checkRead(input string name, input logic [15:0] addr, input logic [7:0] exp);
        bus_addr = addr; bus_re = 1'b1;
        @(negedge clk);
        bus_re = 1'b0;
        check({name, "_valid"}, {15'd0, bus_rvalid}, 16'd1);
        check(name, {8'h00, bus_rdata}, {8'h00, exp});
    endtask

    // TMA=A0, TIMA=FE, TAC=05, then 32 ticks: TIMA overflows into the pending window.
    task automatic setupOverflow();
        doReset();
        busWrite(16'hFF04, 8'h00);
        busWrite(16'hFF06, 8'hA0);
        busWrite(16'hFF05, 8'hFE);
        busWrite(16'hFF07, 8'h05);
        tick(32);
        idle(1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 16'hFF07, 8'h00, 1'b1, 8'hF8};
        vecs[1]  = '{1'b0, 1'b1, 16'hFF04, 8'h00, 1'b1, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 16'hFF06, 8'h5A, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 16'hFF06, 8'h00, 1'b1, 8'h5A};
        vecs[4]  = '{1'b1, 1'b0, 16'hFF07, 8'h06, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 16'hFF07, 8'h00, 1'b1, 8'hFE};
        vecs[6]  = '{1'b1, 1'b0, 16'hFF05, 8'h77, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 1'b1, 16'hFF05, 8'h00, 1'b1, 8'h77};
        vecs[8]  = '{1'b1, 1'b0, 16'hFF08, 8'h12, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 1'b1, 16'hFF08, 8'h00, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 1'b1, 16'hFF03, 8'h00, 1'b0, 8'h00};
        vecs[11] = '{1'b1, 1'b0, 16'hFF03, 8'h99, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 1'b1, 16'hFF06, 8'h00, 1'b1, 8'h5A};
        vecs[13] = '{1'b0, 1'b1, 16'hFF05, 8'h00, 1'b1, 8'h77};
        vecs[14] = '{1'b1, 1'b1, 16'hFF06, 8'h11, 1'b1, 8'h5A};
        vecs[15] = '{1'b0, 1'b1, 16'hFF06, 8'h00, 1'b1, 8'h11};
        vecs[16] = '{1'b0, 1'b1, 16'hFF07, 8'h00, 1'b1, 8'hFE};

        // Reset state
        doReset();
        check("rst_rvalid", {15'd0, bus_rvalid}, 16'd0);
        check("rst_rdata", {8'h00, bus_rdata}, 16'h0000);
        check("rst_irq", {15'd0, irq_timer}, 16'd0);

        // Register access table, counter held still
        for (int i = 0; i < 17; i++) begin
            bus_addr = vecs[i].addr; bus_wdata = vecs[i].wdata;
            bus_we = vecs[i].we; bus_re = vecs[i].re;
            @(negedge clk);
            bus_we = 1'b0; bus_re = 1'b0;
            check($sformatf("vec%0d_valid", i), {15'd0, bus_rvalid}, {15'd0, vecs[i].expValid});
            check($sformatf("vec%0d_data", i), {8'h00, bus_rdata}, {8'h00, vecs[i].expData});
        end

        // DIV after 256 ticks; response lasts one cycle
        doReset();
        checkRead("t1_tac", 16'hFF07, 8'hF8);
        checkRead("t1_div0", 16'hFF04, 8'h00);
        tick(256);
        checkRead("t1_div1", 16'hFF04, 8'h01);
        idle(1);
        check("t1_rvalid_drop", {15'd0, bus_rvalid}, 16'd0);

        // Overflow, pending, reload from TMA
        setupOverflow();
        irqBase = irqCount;
        checkRead("t2_tima_pend", 16'hFF05, 8'h00);
        check("t2_no_irq_pend", 16'(irqCount - irqBase), 16'd0);
        tick(4);
        idle(2);
        checkRead("t2_tima_reload", 16'hFF05, 8'hA0);
        check("t2_irq_once", 16'(irqCount - irqBase), 16'd1);

        // TIMA write during pending cancels reload and irq
        setupOverflow();
        irqBase = irqCount;
        busWrite(16'hFF05, 8'h33);
        tick(8);
        idle(2);
        checkRead("t3_tima", 16'hFF05, 8'h33);
        check("t3_no_irq", 16'(irqCount - irqBase), 16'd0);

        // TMA write in the reload cycle is what gets loaded
        setupOverflow();
        irqBase = irqCount;
        tick(4);
        busWrite(16'hFF06, 8'h55);
        idle(2);
        checkRead("t4_tima", 16'hFF05, 8'h55);
        checkRead("t4_tma", 16'hFF06, 8'h55);
        check("t4_irq_once", 16'(irqCount - irqBase), 16'd1);

        // DIV write while the selected bit is high
        doReset();
        busWrite(16'hFF07, 8'h05);
        busWrite(16'hFF05, 8'h10);
        tick(8);
        busWrite(16'hFF04, 8'hC3);
        idle(2);
`ifdef TIMER_DIV_GLITCH_EN
        checkRead("t5_tima", 16'hFF05, 8'h11);
`else
        checkRead("t5_tima", 16'hFF05, 8'h10);
`endif
        checkRead("t5_div", 16'hFF04, 8'h00);

        // Accesses just outside the window touch nothing
        doReset();
        tick(256);
        busWrite(16'hFF03, 8'h00);
        busWrite(16'hFF08, 8'h07);
        bus_addr = 16'hFF08; bus_re = 1'b1;
        @(negedge clk);
        bus_re = 1'b0;
        check("t6_out_valid", {15'd0, bus_rvalid}, 16'd0);
        checkRead("t6_div", 16'hFF04, 8'h01);
        checkRead("t6_tac", 16'hFF07, 8'hF8);
        checkRead("t6_tima", 16'hFF05, 8'h00);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
